// File: rtl/palette_controller_pkg.sv
// Shared Mandelbrot palette definitions: iteration limits, colour format,
// config register map, palette FSM states and the iteration clamp.
package mandelbrot_pkg;

    localparam int MAX_ITERATIONS = 1023;
    localparam int ITER_BITS      = 10;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } colour_t;

    typedef enum logic [1:0] {
        CFG_COLOURS_12 = 2'd0,
        CFG_COLOURS_34 = 2'd1,
        CFG_COLOURS_56 = 2'd2,
        CFG_ITERATIONS = 2'd3
    } cfg_addr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        LOAD   = 2'd2,
        COMMIT = 2'd3
    } pal_state_t;

    // Same rule as the generator: 0 or anything past the limit means one colour.
    function automatic logic [31:0] clamp_iterations(input logic [31:0] iterations);
        if (iterations == 32'd0 || iterations > 32'(MAX_ITERATIONS))
            return 32'd1;
        return iterations;
    endfunction

endpackage

// File: rtl/palette_controller_ram.sv
// Simple dual-port palette RAM: one write port, one read port with a
// registered 1-cycle read. Banking is folded into ADDR_W by the parent.
module palette_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_addr] <= wr_data;
        rd_data <= mem_q[rd_addr];
    end

endmodule

// File: rtl/palette_controller.sv
// Palette controller: sequences the colour map generator, fills palette RAM
// and serves lookups. PALETTE_DOUBLE_BUFFER_EN selects a two-bank palette.
module palette_controller #(
    parameter int ITER_BITS   = 10,
    parameter int COLOUR_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_addr,
    input  logic [31:0]            cfg_wdata,
    input  logic                   reload,
    output logic                   gen_req,
    input  logic                   gen_ack,
    input  logic                   gen_done,
    output logic [31:0]            gen_colours_12,
    output logic [31:0]            gen_colours_34,
    output logic [31:0]            gen_colours_56,
    output logic [31:0]            gen_iterations,
    input  logic                   gen_valid,
    input  logic [ITER_BITS-1:0]   gen_index,
    input  logic [COLOUR_BITS-1:0] gen_colour,
    input  logic                   lu_req,
    input  logic [ITER_BITS-1:0]   lu_iter,
    output logic                   lu_ready,
    output logic                   lu_valid,
    output logic [COLOUR_BITS-1:0] lu_colour,
    output logic                   loading,
    output logic                   palette_ready,
    output logic                   gen_timeout
);

    import mandelbrot_pkg::*;

`ifdef PALETTE_DOUBLE_BUFFER_EN
    localparam int RAM_AW = ITER_BITS + 1;
    logic active_bank_q;
`else
    localparam int RAM_AW = ITER_BITS;
`endif

    pal_state_t           state_q;
    logic                 pending_q;
    logic [31:0]          colours_12_q, colours_34_q, colours_56_q, iterations_q;
    logic [31:0]          snap_12_q, snap_34_q, snap_56_q, snap_iter_q;
    logic                 gen_req_q, gen_timeout_q, palette_ready_q;
    logic [3:0]           to_cnt_q;
    logic [ITER_BITS-1:0] load_max_q, load_max_d, active_max_q;
    logic                 lu_valid_q, inside_q;
    logic                 lu_accept;
    logic                 ram_we;
    logic [RAM_AW-1:0]    ram_wr_addr, ram_rd_addr;
    logic [COLOUR_BITS-1:0] ram_rd_data;

    assign load_max_d = ITER_BITS'(clamp_iterations(iterations_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            colours_12_q <= '0;
            colours_34_q <= '0;
            colours_56_q <= '0;
            iterations_q <= '0;
        end else if (cfg_we) begin
            case (cfg_addr_t'(cfg_addr))
                CFG_COLOURS_12: colours_12_q <= cfg_wdata;
                CFG_COLOURS_34: colours_34_q <= cfg_wdata;
                CFG_COLOURS_56: colours_56_q <= cfg_wdata;
                CFG_ITERATIONS: iterations_q <= cfg_wdata;
                default:        ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            pending_q       <= 1'b0;
            gen_req_q       <= 1'b0;
            gen_timeout_q   <= 1'b0;
            palette_ready_q <= 1'b0;
            to_cnt_q        <= '0;
            load_max_q      <= '0;
            active_max_q    <= '0;
            snap_12_q       <= '0;
            snap_34_q       <= '0;
            snap_56_q       <= '0;
            snap_iter_q     <= '0;
`ifdef PALETTE_DOUBLE_BUFFER_EN
            active_bank_q   <= 1'b0;
`endif
        end else begin
            // A new request always wins over the IDLE consume, so nothing is lost.
            pending_q <= cfg_we | reload | (pending_q & (state_q != IDLE));
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        snap_12_q   <= colours_12_q;
                        snap_34_q   <= colours_34_q;
                        snap_56_q   <= colours_56_q;
                        snap_iter_q <= iterations_q;
                        load_max_q  <= load_max_d;
                        to_cnt_q    <= '0;
                        gen_req_q   <= 1'b1;
                        state_q     <= REQ;
`ifndef PALETTE_DOUBLE_BUFFER_EN
                        palette_ready_q <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (gen_ack) begin
                        gen_req_q     <= 1'b0;
                        gen_timeout_q <= 1'b0;
                        state_q       <= LOAD;
                    end else if (to_cnt_q == 4'd15) begin
                        gen_req_q     <= 1'b0;
                        gen_timeout_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 4'd1;
                    end
                end
                LOAD: begin
                    if (gen_done)
                        state_q <= COMMIT;
                end
                COMMIT: begin
                    active_max_q    <= load_max_q;
                    palette_ready_q <= 1'b1;
`ifdef PALETTE_DOUBLE_BUFFER_EN
                    active_bank_q   <= ~active_bank_q;
`endif
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_we = (state_q == LOAD) && gen_valid;

`ifdef PALETTE_DOUBLE_BUFFER_EN
    assign ram_wr_addr = {~active_bank_q, gen_index};
    assign ram_rd_addr = {active_bank_q, lu_iter};
    assign lu_ready    = palette_ready_q;
`else
    assign ram_wr_addr = gen_index;
    assign ram_rd_addr = lu_iter;
    assign lu_ready    = palette_ready_q & (state_q == IDLE);
`endif

    assign lu_accept = lu_req & lu_ready;

    // Points inside the set are flagged alongside the RAM read and forced to black.
    always_ff @(posedge clk) begin
        if (reset) begin
            lu_valid_q <= 1'b0;
            inside_q   <= 1'b0;
        end else begin
            lu_valid_q <= lu_accept;
            inside_q   <= (lu_iter >= active_max_q);
        end
    end

    palette_ram #(
        .ADDR_W (RAM_AW),
        .DATA_W (COLOUR_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (gen_colour),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    assign gen_req        = gen_req_q;
    assign gen_colours_12 = snap_12_q;
    assign gen_colours_34 = snap_34_q;
    assign gen_colours_56 = snap_56_q;
    assign gen_iterations = snap_iter_q;
    assign loading        = (state_q != IDLE);
    assign palette_ready  = palette_ready_q;
    assign gen_timeout    = gen_timeout_q;
    assign lu_valid       = lu_valid_q;
    assign lu_colour      = (lu_valid_q && !inside_q) ? ram_rd_data : '0;

endmodule

// File: tb/tb_palette_controller.sv
// Directed bench for palette_controller; honours PALETTE_DOUBLE_BUFFER_EN.
module tb_palette_controller;

    localparam int IB = 10;
    localparam int CB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [31:0]   cfg_wdata;
    logic          reload;
    logic          gen_req, gen_ack, gen_done;
    logic [31:0]   gen_colours_12, gen_colours_34, gen_colours_56, gen_iterations;
    logic          gen_valid;
    logic [IB-1:0] gen_index;
    logic [CB-1:0] gen_colour;
    logic          lu_req;
    logic [IB-1:0] lu_iter;
    logic          lu_ready, lu_valid;
    logic [CB-1:0] lu_colour;
    logic          loading, palette_ready, gen_timeout;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] stream [0:15];

    always #5 clk = ~clk;

    palette_controller #(.ITER_BITS(IB), .COLOUR_BITS(CB)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .reload(reload), .gen_req(gen_req), .gen_ack(gen_ack), .gen_done(gen_done),
        .gen_colours_12(gen_colours_12), .gen_colours_34(gen_colours_34),
        .gen_colours_56(gen_colours_56), .gen_iterations(gen_iterations),
        .gen_valid(gen_valid), .gen_index(gen_index), .gen_colour(gen_colour),
        .lu_req(lu_req), .lu_iter(lu_iter), .lu_ready(lu_ready), .lu_valid(lu_valid),
        .lu_colour(lu_colour), .loading(loading), .palette_ready(palette_ready),
        .gen_timeout(gen_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (gen_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Acts as the generator: ack, stream n entries (done with the last), then pass COMMIT.
    task automatic serve(input int n, output bit seen, output logic [31:0] it_seen,
                         output logic [31:0] c12_seen);
        wait_req(seen);
        it_seen  = gen_iterations;
        c12_seen = gen_colours_12;
        if (seen) begin
            gen_ack = 1'b1;
            tick();
            gen_ack = 1'b0;
            for (int i = 0; i < n; i++) begin
                gen_valid = 1'b1; gen_index = IB'(i); gen_colour = stream[i];
                gen_done = (i == n - 1);
                tick();
            end
            gen_valid = 1'b0; gen_done = 1'b0;
            tick();
        end
    endtask

    task automatic lookup(input logic [IB-1:0] it);
        lu_req = 1'b1; lu_iter = it;
        tick();
        lu_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        vectors++; if (gen_req !== 1'b0) begin miscompares++; $display("FAIL rst_gen_req: got %b expected 0", gen_req); end
        vectors++; if (lu_ready !== 1'b0) begin miscompares++; $display("FAIL rst_lu_ready: got %b expected 0", lu_ready); end
        vectors++; if (lu_valid !== 1'b0) begin miscompares++; $display("FAIL rst_lu_valid: got %b expected 0", lu_valid); end
        vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL rst_loading: got %b expected 0", loading); end
        vectors++; if (palette_ready !== 1'b0) begin miscompares++; $display("FAIL rst_palette_ready: got %b expected 0", palette_ready); end
        vectors++; if (gen_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_gen_timeout: got %b expected 0", gen_timeout); end
        vectors++; if (lu_colour !== 16'h0000) begin miscompares++; $display("FAIL rst_lu_colour: got %h expected 0000", lu_colour); end
        vectors++; if (gen_iterations !== 32'd0 || gen_colours_12 !== 32'd0 || gen_colours_34 !== 32'd0 || gen_colours_56 !== 32'd0) begin
            miscompares++; $display("FAIL rst_gen_data: got %h/%h expected 0", gen_iterations, gen_colours_12); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_load();
        bit seen;
        logic [31:0] it_s, c12_s;
        logic [15:0] exp_c [0:3];
        exp_c[0] = 16'hF800; exp_c[1] = 16'h07E0; exp_c[2] = 16'h001F; exp_c[3] = 16'hFFFF;
        cfg_write(2'd0, 32'h07E0_F800);
        cfg_write(2'd3, 32'd4);
        pulse_reload();
        // The first write already launched a request, before iterations changed.
        stream[0] = 16'h1111;
        serve(1, seen, it_s, c12_s);
        vectors++; if (!seen || it_s !== 32'd0) begin miscompares++; $display("FAIL basic_first_req: got seen=%b iter=%0d expected 1/0", seen, it_s); end
        for (int i = 0; i < 4; i++) stream[i] = exp_c[i];
        serve(4, seen, it_s, c12_s);
        vectors++; if (!seen || it_s !== 32'd4) begin miscompares++; $display("FAIL basic_req_iter: got seen=%b iter=%0d expected 1/4", seen, it_s); end
        vectors++; if (c12_s !== 32'h07E0_F800) begin miscompares++; $display("FAIL basic_req_c12: got %h expected 07e0f800", c12_s); end
        vectors++; if (palette_ready !== 1'b1 || loading !== 1'b0) begin miscompares++; $display("FAIL basic_ready: got ready=%b loading=%b expected 1/0", palette_ready, loading); end
        for (int i = 0; i < 4; i++) begin
            lookup(IB'(i));
            vectors++; if (lu_valid !== 1'b1 || lu_colour !== exp_c[i]) begin
                miscompares++; $display("FAIL basic_lookup%0d: got v=%b c=%h expected 1/%h", i, lu_valid, lu_colour, exp_c[i]); end
        end
        lookup(IB'(7));
        vectors++; if (lu_valid !== 1'b1 || lu_colour !== 16'h0000) begin miscompares++; $display("FAIL inside_set_7: got v=%b c=%h expected 1/0000", lu_valid, lu_colour); end
        lookup(IB'(4));
        vectors++; if (lu_valid !== 1'b1 || lu_colour !== 16'h0000) begin miscompares++; $display("FAIL inside_set_4: got v=%b c=%h expected 1/0000", lu_valid, lu_colour); end
        tick(); tick(); tick();
        vectors++; if (lu_valid !== 1'b0 || gen_req !== 1'b0 || loading !== 1'b0) begin
            miscompares++; $display("FAIL basic_quiet: got v=%b req=%b loading=%b expected 0/0/0", lu_valid, gen_req, loading); end
    endtask

    task automatic test_clamp();
        bit seen;
        logic [31:0] it_s, c12_s;
        cfg_write(2'd3, 32'd0);
        stream[0] = 16'hABCD;
        serve(1, seen, it_s, c12_s);
        vectors++; if (!seen || it_s !== 32'd0) begin miscompares++; $display("FAIL clamp0_req: got seen=%b iter=%0d expected 1/0", seen, it_s); end
        lookup(IB'(0));
        vectors++; if (lu_colour !== 16'hABCD) begin miscompares++; $display("FAIL clamp0_idx0: got %h expected abcd", lu_colour); end
        lookup(IB'(1));
        vectors++; if (lu_valid !== 1'b1 || lu_colour !== 16'h0000) begin miscompares++; $display("FAIL clamp0_idx1: got v=%b c=%h expected 1/0000", lu_valid, lu_colour); end
        cfg_write(2'd3, 32'd2000);
        stream[0] = 16'h1234; stream[1] = 16'h5555;
        serve(2, seen, it_s, c12_s);
        vectors++; if (!seen || it_s !== 32'd2000) begin miscompares++; $display("FAIL clamp2000_req: got seen=%b iter=%0d expected 1/2000", seen, it_s); end
        lookup(IB'(0));
        vectors++; if (lu_colour !== 16'h1234) begin miscompares++; $display("FAIL clamp2000_idx0: got %h expected 1234", lu_colour); end
        lookup(IB'(1));
        vectors++; if (lu_colour !== 16'h0000) begin miscompares++; $display("FAIL clamp2000_idx1: got %h expected 0000", lu_colour); end
    endtask

    task automatic test_timeout();
        bit seen;
        int cnt;
        logic [31:0] it_s, c12_s;
        cfg_write(2'd3, 32'd4);
        wait_req(seen);
        cnt = 0;
        for (int i = 0; i < 40 && gen_req === 1'b1; i++) begin
            cnt++;
            tick();
        end
        vectors++; if (!seen || cnt != 16) begin miscompares++; $display("FAIL timeout_req_cycles: got %0d expected 16", cnt); end
        vectors++; if (gen_timeout !== 1'b1 || loading !== 1'b0) begin miscompares++; $display("FAIL timeout_flag: got to=%b loading=%b expected 1/0", gen_timeout, loading); end
        tick(); tick();
        vectors++; if (gen_timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %b expected 1", gen_timeout); end
`ifdef PALETTE_DOUBLE_BUFFER_EN
        vectors++; if (palette_ready !== 1'b1) begin miscompares++; $display("FAIL timeout_ready_db: got %b expected 1", palette_ready); end
`else
        vectors++; if (palette_ready !== 1'b0) begin miscompares++; $display("FAIL timeout_ready_sb: got %b expected 0", palette_ready); end
`endif
        pulse_reload();
        for (int i = 0; i < 4; i++) stream[i] = 16'hA000 + 16'(i);
        serve(4, seen, it_s, c12_s);
        vectors++; if (!seen || gen_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_clear: got seen=%b to=%b expected 1/0", seen, gen_timeout); end
        lookup(IB'(3));
        vectors++; if (lu_colour !== 16'hA003) begin miscompares++; $display("FAIL timeout_reload_lookup: got %h expected a003", lu_colour); end
    endtask

    task automatic test_cfg_during_load();
        bit seen;
        logic [31:0] it_s, c12_s;
        pulse_reload();
        wait_req(seen);
        vectors++; if (!seen || gen_iterations !== 32'd4) begin miscompares++; $display("FAIL cdl_first_iter: got seen=%b iter=%0d expected 1/4", seen, gen_iterations); end
        gen_ack = 1'b1;
        tick();
        gen_ack = 1'b0;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h1234_5678;
        gen_valid = 1'b1; gen_index = IB'(0); gen_colour = 16'hC000;
        tick();
        cfg_addr = 2'd3; cfg_wdata = 32'd8;
        gen_index = IB'(1); gen_colour = 16'hC001;
        tick();
        cfg_we = 1'b0;
        gen_index = IB'(2); gen_colour = 16'hC002;
        tick();
        vectors++; if (gen_colours_12 !== 32'h07E0_F800 || gen_iterations !== 32'd4) begin
            miscompares++; $display("FAIL cdl_snapshot_held: got %h/%0d expected 07e0f800/4", gen_colours_12, gen_iterations); end
        gen_index = IB'(3); gen_colour = 16'hC003; gen_done = 1'b1;
        tick();
        gen_valid = 1'b0; gen_done = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) stream[i] = 16'h0F00 + 16'(i);
        serve(8, seen, it_s, c12_s);
        vectors++; if (!seen || it_s !== 32'd8 || c12_s !== 32'h1234_5678) begin
            miscompares++; $display("FAIL cdl_second_req: got seen=%b iter=%0d c12=%h expected 1/8/12345678", seen, it_s, c12_s); end
        lookup(IB'(5));
        vectors++; if (lu_colour !== 16'h0F05) begin miscompares++; $display("FAIL cdl_lookup5: got %h expected 0f05", lu_colour); end
        lookup(IB'(7));
        vectors++; if (lu_colour !== 16'h0F07) begin miscompares++; $display("FAIL cdl_lookup7: got %h expected 0f07", lu_colour); end
        lookup(IB'(8));
        vectors++; if (lu_colour !== 16'h0000) begin miscompares++; $display("FAIL cdl_lookup8: got %h expected 0000", lu_colour); end
        tick(); tick();
        vectors++; if (gen_req !== 1'b0 || loading !== 1'b0) begin miscompares++; $display("FAIL cdl_single_extra: got req=%b loading=%b expected 0/0", gen_req, loading); end
    endtask

    task automatic test_lookup_during_reload();
        bit seen;
        pulse_reload();
        wait_req(seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL ldr_req: got no gen_req expected gen_req"); end
`ifdef PALETTE_DOUBLE_BUFFER_EN
        vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL ldr_ready_db: got %b expected 1", lu_ready); end
        lookup(IB'(2));
        vectors++; if (lu_valid !== 1'b1 || lu_colour !== 16'h0F02) begin miscompares++; $display("FAIL ldr_old_colour: got v=%b c=%h expected 1/0f02", lu_valid, lu_colour); end
`else
        vectors++; if (lu_ready !== 1'b0 || palette_ready !== 1'b0) begin miscompares++; $display("FAIL ldr_ready_sb: got %b/%b expected 0/0", lu_ready, palette_ready); end
        lookup(IB'(2));
        vectors++; if (lu_valid !== 1'b0 || lu_colour !== 16'h0000) begin miscompares++; $display("FAIL ldr_blocked: got v=%b c=%h expected 0/0000", lu_valid, lu_colour); end
`endif
        gen_ack = 1'b1;
        tick();
        gen_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            gen_valid = 1'b1; gen_index = IB'(i); gen_colour = 16'h2200 + 16'(i);
            gen_done = (i == 7);
            tick();
        end
        gen_valid = 1'b0; gen_done = 1'b0;
`ifdef PALETTE_DOUBLE_BUFFER_EN
        vectors++; if (loading !== 1'b1 || lu_ready !== 1'b1) begin miscompares++; $display("FAIL ldr_commit_db: got loading=%b ready=%b expected 1/1", loading, lu_ready); end
`else
        vectors++; if (loading !== 1'b1 || lu_ready !== 1'b0) begin miscompares++; $display("FAIL ldr_commit_sb: got loading=%b ready=%b expected 1/0", loading, lu_ready); end
`endif
        tick();
        vectors++; if (lu_ready !== 1'b1 || palette_ready !== 1'b1) begin miscompares++; $display("FAIL ldr_after_commit: got %b/%b expected 1/1", lu_ready, palette_ready); end
        lookup(IB'(2));
        vectors++; if (lu_colour !== 16'h2202) begin miscompares++; $display("FAIL ldr_new_colour: got %h expected 2202", lu_colour); end
    endtask

    task automatic test_reset_mid_load();
        bit seen;
        pulse_reload();
        wait_req(seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL rml_req: got no gen_req expected gen_req"); end
        gen_ack = 1'b1;
        tick();
        gen_ack = 1'b0;
        gen_valid = 1'b1; gen_index = IB'(0); gen_colour = 16'h7777;
        tick();
        gen_valid = 1'b0;
        vectors++; if (loading !== 1'b1) begin miscompares++; $display("FAIL rml_in_load: got %b expected 1", loading); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (palette_ready !== 1'b0 || gen_req !== 1'b0) begin miscompares++; $display("FAIL rml_flags: got ready=%b req=%b expected 0/0", palette_ready, gen_req); end
        vectors++; if (loading !== 1'b0 || lu_ready !== 1'b0 || gen_iterations !== 32'd0) begin
            miscompares++; $display("FAIL rml_state: got loading=%b lu_ready=%b iter=%0d expected 0/0/0", loading, lu_ready, gen_iterations); end
        tick(); tick();
        vectors++; if (gen_req !== 1'b0 || loading !== 1'b0) begin miscompares++; $display("FAIL rml_stays_idle: got req=%b loading=%b expected 0/0", gen_req, loading); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0; reload = 1'b0;
        gen_ack = 1'b0; gen_done = 1'b0; gen_valid = 1'b0; gen_index = '0; gen_colour = '0;
        lu_req = 1'b0; lu_iter = '0;
        for (int i = 0; i < 16; i++) stream[i] = 16'h0000;
        test_reset();
        test_basic_load();
        test_clamp();
        test_timeout();
        test_cfg_during_load();
        test_lookup_during_reload();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
